// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use/branch stall detection, EX forwarding select and branch flush control
module hazard_forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [REG_W-1:0] id_write_reg,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             regs_equal,
  output logic [2:0]       forward_a,
  output logic [2:0]       forward_b,
  output logic             stall_needed,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pc_src,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  logic             ex_valid, ex_reg_write, ex_mem_read, ex_uses_rs, ex_uses_rt;
  logic [REG_W-1:0] ex_write_reg, ex_rs, ex_rt;
  logic             mem_valid, mem_reg_write, mem_mem_read;
  logic [REG_W-1:0] mem_write_reg;
  logic             wb_valid, wb_reg_write;
  logic [REG_W-1:0] wb_write_reg;
  logic             ex_w_rs, ex_w_rt, mem_w_rs, mem_w_rt;
  logic             fa_mem, fa_wb, fb_mem, fb_wb;
  logic             branch, load_use, br_alu, br_load, hazard, taken, load;

  function automatic logic writes(input logic v, input logic rw,
                                  input logic [REG_W-1:0] wr, input logic [REG_W-1:0] r);
    return v & rw & (wr == r) & (r != '0);
  endfunction

  always_comb begin
    fa_mem       = ex_uses_rs & writes(mem_valid, mem_reg_write, mem_write_reg, ex_rs);
    fa_wb        = ex_uses_rs & writes(wb_valid, wb_reg_write, wb_write_reg, ex_rs);
    fb_mem       = ex_uses_rt & writes(mem_valid, mem_reg_write, mem_write_reg, ex_rt);
    fb_wb        = ex_uses_rt & writes(wb_valid, wb_reg_write, wb_write_reg, ex_rt);
    forward_a    = rst ? 3'd0 : fa_mem ? 3'd2 : fa_wb ? 3'd1 : 3'd0;
    forward_b    = rst ? 3'd0 : fb_mem ? 3'd2 : fb_wb ? 3'd1 : 3'd0;
    ex_w_rs      = writes(ex_valid, ex_reg_write, ex_write_reg, id_rs);
    ex_w_rt      = writes(ex_valid, ex_reg_write, ex_write_reg, id_rt);
    mem_w_rs     = writes(mem_valid, mem_reg_write, mem_write_reg, id_rs);
    mem_w_rt     = writes(mem_valid, mem_reg_write, mem_write_reg, id_rt);
    branch       = id_beq | id_bne;
    load_use     = ex_mem_read & ((id_uses_rs & ex_w_rs) | (id_uses_rt & ex_w_rt));
    br_alu       = branch & ~ex_mem_read & (ex_w_rs | ex_w_rt);
    // a load in MEM still cannot reach the ID comparator, so it costs one more bubble
    br_load      = branch & ((ex_mem_read & (ex_w_rs | ex_w_rt)) | (mem_mem_read & (mem_w_rs | mem_w_rt)));
    hazard       = ~rst & id_valid & (load_use | br_alu | br_load);
    taken        = id_beq ? regs_equal : id_bne & ~regs_equal;
    stall_needed = hazard;
    pc_write     = ~hazard;
    ifid_write   = ~hazard;
    pc_src       = ~rst & ~hazard & taken;
    ifid_flush   = pc_src;
    load         = id_valid & ~hazard;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {ex_valid, ex_reg_write, ex_mem_read, ex_uses_rs, ex_uses_rt} <= '0;
      {ex_write_reg, ex_rs, ex_rt} <= '0;
      {mem_valid, mem_reg_write, mem_mem_read, mem_write_reg} <= '0;
      {wb_valid, wb_reg_write, wb_write_reg} <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      {wb_valid, wb_reg_write, wb_write_reg} <= {mem_valid, mem_reg_write, mem_write_reg};
      {mem_valid, mem_reg_write, mem_mem_read, mem_write_reg} <= {ex_valid, ex_reg_write, ex_mem_read, ex_write_reg};
      ex_valid     <= load;
      ex_reg_write <= load & id_reg_write;
      ex_mem_read  <= load & id_mem_read;
      ex_uses_rs   <= load & id_uses_rs;
      ex_uses_rt   <= load & id_uses_rt;
      ex_write_reg <= load ? id_write_reg : '0;
      ex_rs        <= load ? id_rs : '0;
      ex_rt        <= load ? id_rt : '0;
      if (stall_needed && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (ifid_flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed pipeline scenarios plus random stimulus against a stage-list reference model
module tb_hazard_forward_ctrl;
  logic clk = 0, rst = 1;
  logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_beq, id_bne, regs_equal;
  logic [4:0] id_rs, id_rt, id_write_reg;
  logic [2:0] forward_a, forward_b;
  logic stall_needed, pc_write, ifid_write, ifid_flush, pc_src;
  logic [15:0] stall_count, flush_count;

  hazard_forward_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_write_reg(id_write_reg), .id_beq(id_beq), .id_bne(id_bne),
    .regs_equal(regs_equal), .forward_a(forward_a), .forward_b(forward_b),
    .stall_needed(stall_needed), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .pc_src(pc_src), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, rw, mr, urs, urt;
    logic [4:0] wr, rs, rt;
  } ent_t;

  ent_t p[3];
  int errs = 0, checks = 0;
  int sc = 0, fc = 0;
  int e_fa, e_fb;
  bit e_st, e_fl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input ent_t e, input logic [4:0] r);
    return e.v && e.rw && e.wr == r && r != 0;
  endfunction

  function automatic int fwd(input bit used, input logic [4:0] r);
    int f = 0;
    for (int s = 2; s >= 1; s--)
      if (used && writes(p[s], r)) f = 3 - s;
    return f;
  endfunction

  task automatic model_eval();
    bit br, haz;
    br = id_beq || id_bne;
    haz = 0;
    for (int s = 0; s < 2; s++) begin
      if (s == 0 && p[0].mr && ((id_uses_rs && writes(p[0], id_rs)) || (id_uses_rt && writes(p[0], id_rt)))) haz = 1;
      if (br && (writes(p[s], id_rs) || writes(p[s], id_rt)) && (p[s].mr || s == 0)) haz = 1;
    end
    e_fa = rst ? 0 : fwd(p[0].urs, p[0].rs);
    e_fb = rst ? 0 : fwd(p[0].urt, p[0].rt);
    e_st = !rst && id_valid && haz;
    e_fl = !rst && !e_st && (id_beq ? regs_equal : (id_bne && !regs_equal));
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
    chk("forward_a", forward_a, e_fa);
    chk("forward_b", forward_b, e_fb);
    chk("stall_needed", stall_needed, e_st);
    chk("pc_write", pc_write, !e_st);
    chk("ifid_write", ifid_write, !e_st);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("pc_src", pc_src, e_fl);
    chk("stall_count", stall_count, sc);
    chk("flush_count", flush_count, fc);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      p[0] = '0; p[1] = '0; p[2] = '0; sc = 0; fc = 0;
    end else begin
      if (e_st && sc < 65535) sc++;
      if (e_fl && fc < 65535) fc++;
      p[2] = p[1];
      p[1] = p[0];
      p[0] = (!e_st && id_valid) ? ent_t'{1'b1, id_reg_write, id_mem_read, id_uses_rs, id_uses_rt,
                                          id_write_reg, id_rs, id_rt} : '0;
    end
    #1;
  endtask

  task automatic id_in(input bit v, input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                       input bit rw, input bit mr, input logic [4:0] wr, input bit beq, input bit bne, input bit eq);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_write_reg = wr; id_beq = beq; id_bne = bne; regs_equal = eq;
  endtask

  task automatic nop();
    id_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; nop(); settle(); tick(); rst = 0;
  endtask

  initial begin
    nop();
    @(posedge clk); #1;
    // 1: add $3,$1,$2 ; sub $4,$3,$5
    do_reset();
    id_in(1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 0); settle(); tick();
    id_in(1, 3, 5, 1, 1, 1, 0, 4, 0, 0, 0); settle(); chk("s1_stall", stall_needed, 0); tick();
    nop(); settle(); chk("s1_fa", forward_a, 2); chk("s1_fb", forward_b, 0); tick();
    // 2: lw $3,0($1) ; add $4,$3,$3
    do_reset();
    id_in(1, 1, 3, 1, 0, 1, 1, 3, 0, 0, 0); settle(); tick();
    id_in(1, 3, 3, 1, 1, 1, 0, 4, 0, 0, 0); settle();
    chk("s2_stall", stall_needed, 1); chk("s2_pcw", pc_write, 0); chk("s2_ifw", ifid_write, 0); tick();
    settle(); chk("s2_release", stall_needed, 0); tick();
    nop(); settle(); chk("s2_fa", forward_a, 1); chk("s2_fb", forward_b, 1); chk("s2_sc", stall_count, 1); tick();
    // 3: MEM beats WB, then $0 never forwards
    do_reset();
    id_in(1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 0); settle(); tick();
    settle(); tick();
    id_in(1, 3, 3, 1, 1, 1, 0, 5, 0, 0, 0); settle(); tick();
    id_in(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0); settle(); chk("s3_fa", forward_a, 2); tick();
    id_in(1, 0, 0, 1, 1, 1, 0, 6, 0, 0, 0); settle(); chk("s3_zero_stall", stall_needed, 0); tick();
    nop(); settle(); chk("s3_zero_fa", forward_a, 0); chk("s3_zero_fb", forward_b, 0); tick();
    // 4: lw $2 ; beq $2,$7 taken
    do_reset();
    id_in(1, 1, 2, 1, 0, 1, 1, 2, 0, 0, 0); settle(); tick();
    id_in(1, 2, 7, 1, 1, 0, 0, 0, 1, 0, 1); settle(); chk("s4_stall1", stall_needed, 1); tick();
    settle(); chk("s4_stall2", stall_needed, 1); tick();
    settle(); chk("s4_go", stall_needed, 0); chk("s4_pcsrc", pc_src, 1); chk("s4_flush", ifid_flush, 1); tick();
    nop(); settle(); chk("s4_pcsrc_off", pc_src, 0); chk("s4_flush_off", ifid_flush, 0);
    chk("s4_fc", flush_count, 1); chk("s4_sc", stall_count, 2); tick();
    // 5: add $2 ; bne $2,$7 with equal operands
    do_reset();
    id_in(1, 1, 3, 1, 1, 1, 0, 2, 0, 0, 0); settle(); tick();
    id_in(1, 2, 7, 1, 1, 0, 0, 0, 0, 1, 1); settle(); chk("s5_stall", stall_needed, 1); tick();
    settle(); chk("s5_go", stall_needed, 0); chk("s5_pcsrc", pc_src, 0); chk("s5_flush", ifid_flush, 0); tick();
    nop(); settle(); chk("s5_sc", stall_count, 1); tick();
    // 6: reset during the second branch-on-load stall
    do_reset();
    id_in(1, 1, 2, 1, 0, 1, 1, 2, 0, 0, 0); settle(); tick();
    id_in(1, 2, 7, 1, 1, 0, 0, 0, 1, 0, 1); settle(); tick();
    rst = 1; settle();
    chk("s6_rst_stall", stall_needed, 0); chk("s6_rst_pcw", pc_write, 1); chk("s6_rst_pcsrc", pc_src, 0); tick();
    rst = 0; settle();
    chk("s6_post_stall", stall_needed, 0); chk("s6_post_sc", stall_count, 0);
    chk("s6_post_fc", flush_count, 0); chk("s6_post_fa", forward_a, 0); tick();
    // random traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 3);
      rst = ($urandom_range(0, 49) == 0);
      id_in($urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            k == 1, k == 2, 1'($urandom));
      settle(); tick();
    end
    rst = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Hazard detection and forwarding controller for the 5-stage MIPS pipeline datapath. It drives the datapath's forwardA/forwardB, stall_needed, pcWrite, ifidWrite, ifidFlush and pcSrc inputs, and consumes the datapath's regs_equal output. It keeps shadow copies of the ID/EX, EX/MEM and MEM/WB destination and control fields so that every decision is made locally from one cycle of ID-stage decode.

Parameters:
REG_W, 5, register index width
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID holds a real instruction (0 = bubble)
id_rs  in  REG_W  rs field in ID
id_rt  in  REG_W  rt field in ID
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_reg_write  in  1  instruction writes a register
id_mem_read  in  1  instruction is a load
id_write_reg  in  REG_W  destination after regDst mux
id_beq  in  1  branch-if-equal in ID
id_bne  in  1  branch-if-not-equal in ID
regs_equal  in  1  ID comparator result from the datapath
forward_a  out  3  EX operand A select: 0 = ID/EX, 1 = MEM/WB, 2 = EX/MEM
forward_b  out  3  EX operand B select, same encoding
stall_needed  out  1  inject a bubble into ID/EX
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  zero IF/ID on the next edge
pc_src  out  1  1 = take the branch target
stall_count  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of taken branches

Behaviour:
- Shadow stages: ex_*, mem_* and wb_*, each holding {valid, reg_write, mem_read, write_reg}. ex_* also holds {rs, rt, uses_rs, uses_rt}.
- Every non-reset edge: wb <= mem, mem <= ex.
- Every non-reset edge: ex <= ID fields when stall_needed = 0 and id_valid = 1; otherwise ex <= bubble (all zero).
- A stage "writes r" only when valid = 1, reg_write = 1, write_reg == r and r != 0.
- Forwarding is combinational from the ex_* shadow, zero latency.
  - forward_a = 2 if mem writes ex.rs and ex.uses_rs.
  - Else forward_a = 1 if wb writes ex.rs and ex.uses_rs.
  - Else forward_a = 0.
  - forward_b is the same using rt. Priority is MEM over WB. Values 3-7 are never driven.
- Stall conditions are combinational. They apply only when id_valid = 1. A source is "used" when it is rs with id_uses_rs = 1, or rt with id_uses_rt = 1.
  - Load-use: ex is a load (mem_read = 1) and ex writes a used source.
  - Branch-on-ALU: id_beq or id_bne, and ex writes rs or rt with ex.mem_read = 0. Costs 1 stall.
  - Branch-on-load: id_beq or id_bne, and ex or mem is a load that writes rs or rt. Costs 2 stalls total, 1 if the load is already in mem.
- When any stall condition holds: stall_needed = 1, pc_write = 0, ifid_write = 0, ifid_flush = 0, pc_src = 0.
- No stall condition:
  - stall_needed = 0, pc_write = 1, ifid_write = 1.
  - taken = (id_beq & regs_equal) | (id_bne & ~regs_equal).
  - pc_src = taken, ifid_flush = taken. Both last exactly one cycle because the flushed slot arrives with id_valid = 0.
- id_beq and id_bne both high is illegal. The bench must not drive it. The DUT treats it as beq.
- Counters:
  - stall_count increments on each edge where stall_needed = 1.
  - flush_count increments on each edge where ifid_flush = 1.
  - Both hold at all-ones.
- Reset (rst = 1 at an edge): all shadow valids and fields = 0, both counters = 0.
  - While rst = 1, outputs are forced to: forward_a = 0, forward_b = 0, stall_needed = 0, pc_write = 1, ifid_write = 1, ifid_flush = 0, pc_src = 0.
  - Reset mid-stall discards pending hazards; the first post-reset cycle sees an empty pipeline.
- Writes to $0 never forward or stall.

Test Plan:
1. add $3,$1,$2 then sub $4,$3,$5 back-to-back -> in the sub's EX cycle forward_a = 2, forward_b = 0, no stall.
2. lw $3,0($1) then add $4,$3,$3 -> exactly 1 cycle of stall_needed = 1 with pc_write = ifid_write = 0. Next cycle forward_a = forward_b = 1. stall_count = 1.
3. add $3,... ; add $3,... ; add $5,$3,$3 -> forward_a = 2 (MEM beats WB). Then add $0,$1,$2 ; add $6,$0,$0 -> forward_a = 0, no stall.
4. lw $2 then beq $2,$7 with regs_equal = 1 on release -> 2 stall cycles, then pc_src = ifid_flush = 1 for exactly 1 cycle. flush_count = 1, stall_count = 2.
5. add $2 then bne $2,$7, regs_equal = 1 -> 1 stall cycle, then pc_src = 0 and ifid_flush = 0.
6. Assert rst during the second stall cycle of scenario 4 -> next cycle all outputs at reset values, counters = 0, no forwarding until new instructions retire.
